// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and
// offsets of the registers inside the memory-mapped I/O window.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] IO_LEDS  = 16'h0;
    localparam logic [15:0] IO_TIMER = 16'h2;

endpackage

// File: rtl/dmem_ram.sv
// Single-port DEPTH x 16 data RAM: synchronous write, combinational read so
// the responder can capture load data on the same edge a transaction commits.
module dmem_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    // NOTE: the array has no reset; clearing it would force flops instead of RAM.
    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder for the 16-bit MIPS core: fixed wait states, busy stall,
// RAM below IO_BASE and an I/O window with an LED register and free-running timer.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] IO_BASE     = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        ready,
    output logic [15:0] leds
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state, next_state;
    logic [3:0]  cnt;
    logic [15:0] addr_q, wdata_q;
    logic        we_q;
    logic [15:0] timer;

    logic        req;
    logic        commit;
    logic [15:0] cmd_addr, cmd_wdata;
    logic        cmd_we;
    logic        is_io;
    logic [15:0] io_off;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic [15:0] read_data;

    assign req = memread | memwrite;

    // In IDLE the request commits straight from the ports when there are no
    // wait states; otherwise the values latched at acceptance are used.
    assign cmd_addr  = (state == IDLE) ? addr     : addr_q;
    assign cmd_wdata = (state == IDLE) ? wdata    : wdata_q;
    assign cmd_we    = (state == IDLE) ? memwrite : we_q;

    assign is_io  = (cmd_addr >= IO_BASE);
    assign io_off = (cmd_addr - IO_BASE) & 16'hFFFE;

    // Only IDLE and WAIT can step into DONE, so this marks the DONE-entry edge.
    assign commit = (next_state == DONE);
    assign ram_we = commit & cmd_we & ~is_io;

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (cmd_addr[AW:1]),
        .wdata (cmd_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        if (!is_io) begin
            read_data = ram_rdata;
        end else if (io_off == IO_LEDS) begin
            read_data = leds;
        end else if (io_off == IO_TIMER) begin
            read_data = timer;
        end else begin
            read_data = 16'h0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            IDLE: if (req) next_state = (WAIT_CYCLES == 0) ? DONE : WAIT;
            WAIT: if (cnt == 4'd0) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy  = ((state == IDLE) && req) || (state == WAIT);
        ready = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 4'd0;
            addr_q  <= 16'h0;
            wdata_q <= 16'h0;
            we_q    <= 1'b0;
            rdata   <= 16'h0;
        end else begin
            if ((state == IDLE) && req) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                we_q    <= memwrite;
                cnt     <= CNT_INIT;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rdata <= cmd_we ? 16'h0 : read_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds  <= 16'h0;
            timer <= 16'h0;
        end else begin
            if (commit && cmd_we && is_io && (io_off == IO_LEDS)) begin
                leds <= cmd_wdata;
            end
            if (commit && cmd_we && is_io && (io_off == IO_TIMER)) begin
                timer <= cmd_wdata;
            end else begin
                timer <= timer + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// loads/stores compared against an address-level memory/IO model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread, memwrite;
    logic [15:0] addr, wdata;
    logic [15:0] rdata, leds;
    logic        busy, ready;

    logic        memread0, memwrite0;
    logic [15:0] addr0, wdata0;
    logic [15:0] rdata0, leds0;
    logic        busy0, ready0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: word array, LED value, timer as base + elapsed edges.
    logic [15:0] m_mem [64];
    logic [15:0] m_leds;
    logic [15:0] m_tbase;
    int          m_tload;

    logic [15:0] last_got;
    int          last_c;

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2), .IO_BASE(16'hFF00)) u_dut (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy),
        .ready(ready), .leds(leds)
    );

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0), .IO_BASE(16'hFF00)) u_dut0 (
        .clk(clk), .reset(reset), .memread(memread0), .memwrite(memwrite0),
        .addr(addr0), .wdata(wdata0), .rdata(rdata0), .busy(busy0),
        .ready(ready0), .leds(leds0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a, input int c);
        logic [15:0] off;
        if (a < 16'hFF00) return m_mem[(a >> 1) % 64];
        off = (a - 16'hFF00) & 16'hFFFE;
        if (off == 16'h0) return m_leds;
        if (off == 16'h2) return m_tbase + 16'(c - 1 - m_tload);
        return 16'h0;
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [15:0] d, input int c);
        logic [15:0] off;
        if (a < 16'hFF00) begin
            m_mem[(a >> 1) % 64] = d;
        end else begin
            off = (a - 16'hFF00) & 16'hFFFE;
            if (off == 16'h0) m_leds = d;
            else if (off == 16'h2) begin
                m_tbase = d;
                m_tload = c;
            end
        end
    endfunction

    // Issues one request, drops it after acceptance, waits for ready (bounded),
    // then steps to the following IDLE cycle.
    task automatic do_req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] got, output int busy_n, output int lat, output int c);
        bit done;
        @(negedge clk);
        memread = rd; memwrite = wr; addr = a; wdata = d;
        busy_n = 0; lat = 0; done = 0; c = 0; got = 'x;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (busy) busy_n++;
            if (ready) begin
                done = 1;
                c    = cyc;
                got  = rdata;
            end else begin
                @(posedge clk);
                #1;
                lat++;
                memread = 0; memwrite = 0;
            end
        end
        memread = 0; memwrite = 0;
        check("ready_seen", 16'(done), 16'd1);
        if (done) @(posedge clk);
    endtask

    task automatic txn(input string tag, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] d);
        logic [15:0] got, exp;
        int busy_n, lat, c;
        do_req(rd, wr, a, d, got, busy_n, lat, c);
        check({tag, "_latency"}, 16'(lat), 16'd3);
        check({tag, "_busy"}, 16'(busy_n), 16'd3);
        if (wr) begin
            exp = 16'h0;
            model_write(a, d, c);
        end else begin
            exp = model_read(a, c);
        end
        check({tag, "_rdata"}, got, exp);
        last_got = got;
        last_c   = c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic r, w;
        logic [15:0] a;

        reset = 1'b1;
        memread = 0; memwrite = 0; addr = 0; wdata = 0;
        memread0 = 0; memwrite0 = 0; addr0 = 0; wdata0 = 0;
        m_leds = 0; m_tbase = 0; m_tload = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 16'h0);
        check("rst_leds", leds, 16'h0);
        check("rst_ready", 16'(ready), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        m_tload = cyc;

        // Basic store/load, odd address ignores bit 0.
        txn("wr0010", 0, 1, 16'h0010, 16'h1234);
        txn("rd0010", 1, 0, 16'h0010, 16'h0);
        check("rd0010_val", last_got, 16'h1234);
        txn("rd0011", 1, 0, 16'h0011, 16'h0);
        check("rd0011_val", last_got, 16'h1234);

        // Aliasing modulo DEPTH words.
        txn("wr0002", 0, 1, 16'h0002, 16'hA5A5);
        txn("rd0082", 1, 0, 16'h0082, 16'h0);
        check("alias_val", last_got, 16'hA5A5);

        // LED register and unmapped I/O offset.
        txn("wrleds", 0, 1, 16'hFF00, 16'h00FF);
        check("leds_val", leds, 16'h00FF);
        txn("rdff06", 1, 0, 16'hFF06, 16'h0);
        check("ff06_zero", last_got, 16'h0);
        txn("wrff06", 0, 1, 16'hFF06, 16'h5555);
        check("ff06_noeffect", leds, 16'h00FF);
        txn("rdleds", 1, 0, 16'hFF00, 16'h0);

        // Timer load and wrap through 0000.
        txn("wrtimer", 0, 1, 16'hFF02, 16'hFFFE);
        txn("rdtimer", 1, 0, 16'hFF02, 16'h0);
        check("timer_wrap", last_got, 16'h0001);
        repeat (5) @(posedge clk);
        txn("rdtimer2", 1, 0, 16'hFF02, 16'h0);

        // Simultaneous read and write acts as a write.
        txn("both0020", 1, 1, 16'h0020, 16'h7777);
        txn("rd0020", 1, 0, 16'h0020, 16'h0);
        check("both_val", last_got, 16'h7777);

        // Request held high: one transaction per IDLE acceptance (4-cycle period).
        pulses = 0;
        @(negedge clk);
        memread = 1; addr = 16'h0010;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (ready) pulses++;
            @(negedge clk);
        end
        memread = 0;
        check("hold_pulses", 16'(pulses), 16'd3);
        check("hold_rdata", rdata, 16'h1234);
        @(posedge clk);
        #1;

        // Reset in the middle of a write aborts it.
        txn("wr0004", 0, 1, 16'h0004, 16'h1111);
        txn("rd0010b", 1, 0, 16'h0010, 16'h0);
        @(negedge clk);
        memwrite = 1; addr = 16'h0004; wdata = 16'hBEEF;
        @(posedge clk);
        #1;
        memwrite = 0;
        #1;
        reset = 1'b1;
        #1;
        check("abort_rdata", rdata, 16'h0);
        check("abort_leds", leds, 16'h0);
        check("abort_ready", 16'(ready), 16'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_tload = cyc;
        m_tbase = 0;
        m_leds  = 0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (ready) pulses++;
        end
        check("abort_no_ready", 16'(pulses), 16'd0);
        txn("rd0004", 1, 0, 16'h0004, 16'h0);
        check("abort_kept", last_got, 16'h1111);

        // Randomized traffic: fill RAM, then mixed loads/stores over RAM and I/O.
        for (int i = 0; i < 64; i++) begin
            txn("fill", 0, 1, 16'(i * 2), 16'($urandom));
        end
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: begin r = 1; w = 1; end
                1: begin r = 0; w = 1; end
                default: begin r = 1; w = 0; end
            endcase
            if ($urandom_range(0, 3) == 0) a = 16'hFF00 + 16'($urandom_range(0, 15));
            else a = 16'($urandom_range(0, 16'hFEFF));
            txn("rand", r, w, a, 16'($urandom));
        end
        check("rand_leds", leds, m_leds);

        // Zero-wait-state instance: ready the cycle after acceptance.
        @(negedge clk);
        memwrite0 = 1; addr0 = 16'h0008; wdata0 = 16'h4321;
        #1;
        check("w0_busy", 16'(busy0), 16'd1);
        check("w0_ready_pre", 16'(ready0), 16'd0);
        @(posedge clk);
        #1;
        memwrite0 = 0;
        check("w0_ready", 16'(ready0), 16'd1);
        check("w0_wr_rdata", rdata0, 16'h0);
        @(posedge clk);
        #1;
        check("w0_ready_drop", 16'(ready0), 16'd0);
        @(negedge clk);
        memread0 = 1; addr0 = 16'h0008;
        @(posedge clk);
        #1;
        memread0 = 0;
        check("w0_rd_ready", 16'(ready0), 16'd1);
        check("w0_rd_rdata", rdata0, 16'h4321);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
